// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one single-ported word memory.
// Round-robin grant is combinational; the response comes back one cycle after its grant.
module mem_arbiter #(
  parameter int unsigned MEMSIZE = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic        if_err_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic        ls_err_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  localparam int unsigned WORDS = MEMSIZE / 4;

  typedef struct packed {
    logic valid;
    logic owner_ls;
    logic err;
    logic is_write;
  } rsp_t;

  logic        last_ls;
  rsp_t        rsp_q;
  logic        any_gnt, sel_err, sel_wr;
  logic [31:0] sel_addr;
  logic        rd_ok;

  // On contention the port that did not win last time gets the memory.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (!rst_i) begin
      if_gnt_o = if_req_i && (!ls_req_i || last_ls);
      ls_gnt_o = ls_req_i && (!if_req_i || !last_ls);
    end
  end

  assign any_gnt  = if_gnt_o | ls_gnt_o;
  assign sel_addr = ls_gnt_o ? ls_addr_i : if_addr_i;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= WORDS);
  assign sel_wr   = ls_gnt_o & ls_we_i;

  // Errored requests are granted and answered but never touch the memory.
  always_comb begin
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (any_gnt && !sel_err) begin
      mem_addr_o  = {2'b00, sel_addr[31:2]};
      mem_wen_o   = sel_wr;
      mem_wdata_o = sel_wr ? ls_wdata_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_ls <= 1'b0;
      rsp_q   <= '0;
    end else begin
      if (any_gnt) last_ls <= ls_gnt_o;
      rsp_q.valid    <= any_gnt;
      rsp_q.owner_ls <= ls_gnt_o;
      rsp_q.err      <= any_gnt & sel_err;
      rsp_q.is_write <= sel_wr;
    end
  end

  assign rd_ok       = rsp_q.valid & ~rsp_q.err & ~rsp_q.is_write;
  assign if_rvalid_o = rsp_q.valid & ~rsp_q.owner_ls;
  assign ls_rvalid_o = rsp_q.valid &  rsp_q.owner_ls;
  assign if_err_o    = if_rvalid_o & rsp_q.err;
  assign ls_err_o    = ls_rvalid_o & rsp_q.err;
  assign if_rdata_o  = (rd_ok && !rsp_q.owner_ls) ? mem_rdata_i : '0;
  assign ls_rdata_o  = (rd_ok &&  rsp_q.owner_ls) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read word memory.
module tb_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, ls_req_i, ls_we_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] if_rdata_o, ls_rdata_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MEMSIZE(4096)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_err_o(if_err_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_err_o(ls_err_o), .ls_rdata_o(ls_rdata_o),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_wen_o) mem[mem_addr_o[9:0]] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld);
    if_req_i = ir; if_addr_i = ia;
    ls_req_i = lr; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = ld;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
    mem[1] = 32'd7;
    rst_i = 1'b1;
    drive(1, 32'h4, 1, 1, 32'h8, 32'h1234_5678);
    tick(); tick();
    // Reset holds everything quiet even with requests pending.
    chk("rst_if_gnt", {31'b0, if_gnt_o}, 0);
    chk("rst_ls_gnt", {31'b0, ls_gnt_o}, 0);
    chk("rst_wen", {31'b0, mem_wen_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 0);
    chk("rst_rdata", if_rdata_o | ls_rdata_o, 0);

    // Sustained contention right after reset: LS, IF, LS, IF.
    rst_i = 1'b0;
    drive(1, 32'h14, 1, 0, 32'h10, 0);
    chk("c1_gnt", {30'b0, if_gnt_o, ls_gnt_o}, 32'b01);
    chk("c1_addr", mem_addr_o, 4);
    tick();
    chk("c1_ls_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'b01);
    chk("c1_ls_rdata", ls_rdata_o, 32'h104);
    chk("c2_gnt", {30'b0, if_gnt_o, ls_gnt_o}, 32'b10);
    chk("c2_addr", mem_addr_o, 5);
    tick();
    chk("c2_if_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'b10);
    chk("c2_if_rdata", if_rdata_o, 32'h105);
    chk("c2_ls_rdata0", ls_rdata_o, 0);
    chk("c3_gnt", {30'b0, if_gnt_o, ls_gnt_o}, 32'b01);
    tick();
    chk("c4_gnt", {30'b0, if_gnt_o, ls_gnt_o}, 32'b10);

    // Lone IF read of word 1.
    tick();
    drive(1, 32'h4, 0, 0, 0, 0);
    chk("if_gnt_alone", {30'b0, if_gnt_o, ls_gnt_o}, 32'b10);
    chk("if_addr1", mem_addr_o, 1);
    tick();
    chk("if_rvalid_w1", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'b10);
    chk("if_rdata_w1", if_rdata_o, 7);

    // LS write then IF read of the same word.
    drive(0, 0, 1, 1, 32'h8, 32'hDEAD_BEEF);
    chk("wr_gnt", {30'b0, if_gnt_o, ls_gnt_o}, 32'b01);
    chk("wr_wen", {31'b0, mem_wen_o}, 1);
    chk("wr_addr", mem_addr_o, 2);
    chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    tick();
    drive(1, 32'h8, 0, 0, 0, 0);
    chk("wr_ack_valid", {31'b0, ls_rvalid_o}, 1);
    chk("wr_ack_rdata", ls_rdata_o, 0);
    chk("rd8_gnt", {31'b0, if_gnt_o}, 1);
    chk("rd8_wen", {31'b0, mem_wen_o}, 0);
    tick();
    chk("rd8_rvalid", {31'b0, if_rvalid_o}, 1);
    chk("rd8_rdata", if_rdata_o, 32'hDEAD_BEEF);

    // Errors: misaligned LS read, out-of-range IF read, misaligned LS write.
    drive(0, 0, 1, 0, 32'h6, 0);
    chk("e1_gnt", {31'b0, ls_gnt_o}, 1);
    chk("e1_mem", {mem_wen_o, mem_addr_o[30:0]}, 0);
    tick();
    drive(1, 32'h1000, 0, 0, 0, 0);
    chk("e1_resp", {30'b0, ls_rvalid_o, ls_err_o}, 32'b11);
    chk("e1_rdata", ls_rdata_o, 0);
    chk("e2_gnt", {31'b0, if_gnt_o}, 1);
    chk("e2_mem", {mem_wen_o, mem_addr_o[30:0]}, 0);
    tick();
    drive(0, 0, 1, 1, 32'hE, 32'hBAD0_BAD0);
    chk("e2_resp", {30'b0, if_rvalid_o, if_err_o}, 32'b11);
    chk("e2_rdata", if_rdata_o, 0);
    chk("e2_ls_err0", {31'b0, ls_err_o}, 0);
    chk("e3_wen", {31'b0, mem_wen_o}, 0);
    chk("e3_wdata", mem_wdata_o, 0);
    tick();
    chk("e3_resp", {29'b0, ls_rvalid_o, ls_err_o, if_rvalid_o}, 32'b110);

    // Back-to-back IF reads 0x0, 0x4, 0x8, 0xC.
    drive(1, 32'h0, 0, 0, 0, 0);
    chk("b0_gnt", {31'b0, if_gnt_o}, 1);
    tick();
    drive(1, 32'h4, 0, 0, 0, 0);
    chk("b0_rdata", if_rdata_o, 32'h100);
    chk("b1_gnt", {31'b0, if_gnt_o}, 1);
    tick();
    drive(1, 32'h8, 0, 0, 0, 0);
    chk("b1_rdata", if_rdata_o, 7);
    chk("b2_gnt", {31'b0, if_gnt_o}, 1);
    tick();
    drive(1, 32'hC, 0, 0, 0, 0);
    chk("b2_rvalid", {31'b0, if_rvalid_o}, 1);
    chk("b2_rdata", if_rdata_o, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("b3_rdata_untouched", if_rdata_o, 32'h103);

    // Reset right after an LS read grant drops the response and re-arms LS priority.
    drive(0, 0, 1, 0, 32'h10, 0);
    chk("r_gnt", {31'b0, ls_gnt_o}, 1);
    tick();
    rst_i = 1'b1;
    drive(1, 32'h4, 1, 0, 32'h10, 0);
    chk("r_rvalid_dropped", {30'b0, if_rvalid_o, ls_rvalid_o}, 0);
    chk("r_rdata", ls_rdata_o, 0);
    chk("r_gnt_off", {30'b0, if_gnt_o, ls_gnt_o}, 0);
    tick();
    chk("r_hold_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 0);
    chk("r_hold_mem", mem_addr_o | mem_wdata_o | {31'b0, mem_wen_o}, 0);
    rst_i = 1'b0;
    #1;
    chk("r_first_contention", {30'b0, if_gnt_o, ls_gnt_o}, 32'b01);
    tick();
    chk("r_first_resp", ls_rdata_o, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEMSIZE, default 4096, memory size in bytes (multiple of 4); word count is MEMSIZE/4.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 if_req_i  in  1  instruction-fetch read request; held with address stable until granted.
REQ-005 if_addr_i  in  32  fetch byte address.
REQ-006 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid_o / if_err_o  out  1/1  fetch response valid / error, one cycle after grant.
REQ-008 if_rdata_o  out  32  fetch read data, qualified by if_rvalid_o.
REQ-009 ls_req_i, ls_we_i  in  1/1  load/store request; ls_we_i=1 write; held stable until granted.
REQ-010 ls_addr_i, ls_wdata_i  in  32/32  load/store byte address, write data.
REQ-011 ls_gnt_o, ls_rvalid_o, ls_err_o  out  1/1/1  load/store grant, response valid, error.
REQ-012 ls_rdata_o  out  32  load data, qualified by ls_rvalid_o.
REQ-013 mem_wen_o  out  1  memory write enable, 1=write.
REQ-014 mem_addr_o  out  32  memory word index.
REQ-015 mem_wdata_o  out  32  memory write data.
REQ-016 mem_rdata_i  in  32  memory read data; registered, valid the cycle after the address is presented.

Function
REQ-017 Grants SHALL be combinational from requests and the last-winner register; at most one grant per cycle.
REQ-018 Single requester SHALL be granted the same cycle it requests.
REQ-019 On contention, the port not granted most recently SHALL win (round-robin); last-winner updates on every grant.
REQ-020 A new grant SHALL be allowed every cycle, including a response cycle (throughput 1/cycle, one response in flight).
REQ-021 Granted valid access: mem_addr_o = addr[31:2]; mem_wen_o = ls_we_i for LS, 0 for IF; mem_wdata_o = ls_wdata_i for LS writes, else 0.
REQ-022 No valid grant: mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-023 Error condition: addr[1:0]!=0 or addr[31:2] >= MEMSIZE/4; granted errored request SHALL drive no memory access (mem_wen_o=0).
REQ-024 Every grant SHALL produce exactly one rvalid pulse to the same port in the next cycle (fixed latency 1).
REQ-025 Response registers: valid, owner (IF/LS), err, is_write, captured at grant.
REQ-026 rdata SHALL equal mem_rdata_i for a successful read response, else 0 (write ack or error).
REQ-027 err SHALL be 1 only in an rvalid cycle whose request met REQ-023.
REQ-028 Write completes at the granting posedge; LS response is a write ack (rvalid=1, rdata=0).
REQ-029 Non-owner port SHALL see rvalid=0, err=0, rdata=0.

Reset
REQ-030 While rst_i=1: all grants 0, all rvalid/err 0, all rdata 0, mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-031 Reset SHALL clear response registers immediately; an in-flight response is dropped, not delivered after reset.
REQ-032 Last-winner SHALL reset to IF, so LS wins the first contention after reset.
REQ-033 First grant possible in the first cycle with rst_i=0.

Verification
REQ-034 Memory word 1 = 7; IF reads 0x4 alone -> if_gnt_o same cycle, mem_addr_o=1; next cycle if_rvalid_o=1, if_rdata_o=7.
REQ-035 Both request in the first cycle after reset -> LS granted; IF granted next cycle; then alternating on sustained contention.
REQ-036 LS writes 0xDEADBEEF to 0x8, then IF reads 0x8 next cycle -> ls_rvalid_o ack with rdata 0; if_rdata_o=0xDEADBEEF.
REQ-037 LS read 0x6 and IF read 0x1000 (MEMSIZE=4096) -> each err=1, rdata=0, mem_wen_o=0, no memory contents change.
REQ-038 Back-to-back IF reads 0x0, 0x4, 0x8 -> grants in 3 consecutive cycles; rvalid in 3 consecutive cycles with words 0, 1, 2.
REQ-039 Assert rst_i in the cycle after a read grant -> rvalid stays 0; outputs per REQ-030; after release LS wins first contention.
